// File: rtl/sh7034_exc_seq.sv
// SH7034 interrupt acceptance sequencer: pushes SR/PC, fetches the handler vector through VBR,
// then hands the new PC and I-mask to the CPU. Every state update is qualified by the clock enable.
module sh7034_exc_seq #(
    parameter int unsigned MAX_WAIT = 0
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_ceR,
    input  logic        i_intReq,
    input  logic [3:0]  i_intLvl,
    input  logic [7:0]  i_intVec,
    input  logic        i_accept,
    input  logic [31:0] i_srIn,
    input  logic [31:0] i_pcIn,
    input  logic [31:0] i_r15In,
    input  logic [31:0] i_vbrIn,
    output logic        o_intAck,
    output logic        o_vectReq,
    output logic        o_busReq,
    output logic        o_busWe,
    output logic [31:0] o_busA,
    output logic [31:0] o_busDo,
    input  logic [31:0] i_busDi,
    input  logic        i_busWait,
    output logic [31:0] o_r15Out,
    output logic        o_r15We,
    output logic [31:0] o_newPc,
    output logic [3:0]  o_newSrI,
    output logic        o_newPcVld,
    output logic        o_busy,
    output logic        o_err
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACK,
        ST_PUSH_SR,
        ST_PUSH_PC,
        ST_VEC_RD,
        ST_DONE
    } state_t;

    state_t      r_state;
    state_t      w_nextState;

    logic [3:0]  r_lvl;
    logic [7:0]  r_vec;
    logic [31:0] r_sr;
    logic [31:0] r_pc;
    logic [31:0] r_sp;
    logic [31:0] r_vbr;
    logic [31:0] r_newPc;
    logic [31:0] r_waitCnt;
    logic        r_r15We;
    logic        r_err;

    logic        w_accept;
    logic        w_timeout;
    logic        w_abort;
    logic        w_pushPcDone;

    assign w_accept     = (r_state == ST_IDLE) && i_intReq && i_accept;
    assign w_timeout    = (MAX_WAIT != 0) && i_busWait && (r_waitCnt == 32'(MAX_WAIT - 1));
    assign w_abort      = o_busReq && w_timeout;
    assign w_pushPcDone = (r_state == ST_PUSH_PC) && !i_busWait;

    // Bus outputs decode purely from the state and latched operands, so they hold steady through stalls.
    always_comb begin
        w_nextState = r_state;
        o_intAck    = 1'b0;
        o_busReq    = 1'b0;
        o_busWe     = 1'b0;
        o_vectReq   = 1'b0;
        o_busA      = 32'h0;
        o_busDo     = 32'h0;
        o_newPcVld  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_intReq && i_accept) w_nextState = ST_ACK;
            end
            ST_ACK: begin
                o_intAck    = 1'b1;
                w_nextState = ST_PUSH_SR;
            end
            ST_PUSH_SR: begin
                o_busReq = 1'b1;
                o_busWe  = 1'b1;
                o_busA   = r_sp - 32'd4;
                o_busDo  = r_sr;
                if (!i_busWait)     w_nextState = ST_PUSH_PC;
                else if (w_timeout) w_nextState = ST_IDLE;
            end
            ST_PUSH_PC: begin
                o_busReq = 1'b1;
                o_busWe  = 1'b1;
                o_busA   = r_sp - 32'd8;
                o_busDo  = r_pc;
                if (!i_busWait)     w_nextState = ST_VEC_RD;
                else if (w_timeout) w_nextState = ST_IDLE;
            end
            ST_VEC_RD: begin
                o_busReq  = 1'b1;
                o_vectReq = 1'b1;
                o_busA    = r_vbr + {22'b0, r_vec, 2'b00};
                if (!i_busWait)     w_nextState = ST_DONE;
                else if (w_timeout) w_nextState = ST_IDLE;
            end
            ST_DONE: begin
                o_newPcVld  = 1'b1;
                w_nextState = ST_IDLE;
            end
            default: w_nextState = ST_IDLE;
        endcase
    end

    // State, operand latches, wait counter and the registered R15/ERR pulses; all frozen while CE is low.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state   <= ST_IDLE;
            r_lvl     <= 4'h0;
            r_vec     <= 8'h0;
            r_sr      <= 32'h0;
            r_pc      <= 32'h0;
            r_sp      <= 32'h0;
            r_vbr     <= 32'h0;
            r_newPc   <= 32'h0;
            r_waitCnt <= 32'h0;
            r_r15We   <= 1'b0;
            r_err     <= 1'b0;
        end else if (i_ceR) begin
            r_state <= w_nextState;
            r_r15We <= w_pushPcDone;
            r_err   <= w_abort;
            if ((MAX_WAIT != 0) && o_busReq && i_busWait && !w_timeout)
                r_waitCnt <= r_waitCnt + 32'd1;
            else
                r_waitCnt <= 32'h0;
            if (w_accept) begin
                r_lvl <= i_intLvl;
                r_vec <= i_intVec;
                r_sr  <= i_srIn;
                r_pc  <= i_pcIn;
                r_sp  <= i_r15In;
                r_vbr <= i_vbrIn;
            end
            if ((r_state == ST_VEC_RD) && !i_busWait)
                r_newPc <= i_busDi;
        end
    end

    assign o_r15We   = r_r15We;
    assign o_r15Out  = r_r15We ? (r_sp - 32'd8) : 32'h0;
    assign o_err     = r_err;
    assign o_busy    = (r_state != ST_IDLE);
    assign o_newPc   = (r_state == ST_DONE) ? r_newPc : 32'h0;
    assign o_newSrI  = (r_state == ST_DONE) ? r_lvl : 4'h0;

endmodule

// File: tb/tb_sh7034_exc_seq.sv
// Directed bench for sh7034_exc_seq: walks full entry sequences cycle by cycle against
// hand-computed addresses, data and pulse timing, plus stall, timeout, CE freeze and reset cases.
module tb_sh7034_exc_seq;

    logic        clk;
    logic        rst;
    logic        ceR;
    logic        intReq;
    logic [3:0]  intLvl;
    logic [7:0]  intVec;
    logic        accept;
    logic [31:0] srIn;
    logic [31:0] pcIn;
    logic [31:0] r15In;
    logic [31:0] vbrIn;
    logic        intAck;
    logic        vectReq;
    logic        busReq;
    logic        busWe;
    logic [31:0] busA;
    logic [31:0] busDo;
    logic [31:0] busDi;
    logic        busWait;
    logic [31:0] r15Out;
    logic        r15We;
    logic [31:0] newPc;
    logic [3:0]  newSrI;
    logic        newPcVld;
    logic        busy;
    logic        err;

    int errCount;
    int checkCount;

    sh7034_exc_seq #(.MAX_WAIT(4)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_ceR      (ceR),
        .i_intReq   (intReq),
        .i_intLvl   (intLvl),
        .i_intVec   (intVec),
        .i_accept   (accept),
        .i_srIn     (srIn),
        .i_pcIn     (pcIn),
        .i_r15In    (r15In),
        .i_vbrIn    (vbrIn),
        .o_intAck   (intAck),
        .o_vectReq  (vectReq),
        .o_busReq   (busReq),
        .o_busWe    (busWe),
        .o_busA     (busA),
        .o_busDo    (busDo),
        .i_busDi    (busDi),
        .i_busWait  (busWait),
        .o_r15Out   (r15Out),
        .o_r15We    (r15We),
        .o_newPc    (newPc),
        .o_newSrI   (newSrI),
        .o_newPcVld (newPcVld),
        .o_busy     (busy),
        .o_err      (err)
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        if (obs !== exp) begin
            errCount++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one accepted request through the whole sequence, inserting 'waits' stall cycles per transfer.
    task automatic applyStimulus(input logic [31:0] sp, input logic [31:0] pc, input logic [31:0] sr,
                                 input logic [31:0] vbr, input logic [7:0] vec, input logic [3:0] lvl,
                                 input int waits, input logic [31:0] rdData,
                                 input logic [31:0] expA0, input logic [31:0] expA1, input logic [31:0] expA2);
        logic [31:0] expA;
        logic [31:0] expD;
        intReq = 1'b1; accept = 1'b1;
        r15In = sp; pcIn = pc; srIn = sr; vbrIn = vbr; intVec = vec; intLvl = lvl;
        busDi = rdData; busWait = 1'b0;
        tick();
        intReq = 1'b0; accept = 1'b0;
        r15In = ~sp; pcIn = ~pc; srIn = ~sr; vbrIn = ~vbr; intVec = ~vec; intLvl = ~lvl;
        @(negedge clk);
        checkOutput("ackPulse", 32'(intAck), 32'd1);
        checkOutput("ackBusy", 32'(busy), 32'd1);
        checkOutput("ackBusReq", 32'(busReq), 32'd0);
        for (int t = 0; t < 3; t++) begin
            expA = (t == 0) ? expA0 : (t == 1) ? expA1 : expA2;
            expD = (t == 0) ? sr : pc;
            for (int w = 0; w <= waits; w++) begin
                tick();
                busWait = (w < waits);
                busDi = (w < waits) ? 32'hDEADBEEF : rdData;
                @(negedge clk);
                checkOutput("xferReq", 32'(busReq), 32'd1);
                checkOutput("xferWe", 32'(busWe), 32'(t < 2));
                checkOutput("xferAddr", busA, expA);
                if (t < 2) checkOutput("xferData", busDo, expD);
                checkOutput("xferVect", 32'(vectReq), 32'(t == 2));
                checkOutput("xferR15We", 32'(r15We), 32'((t == 2) && (w == 0)));
                if ((t == 2) && (w == 0)) checkOutput("r15Out", r15Out, expA1);
                checkOutput("xferAck", 32'(intAck), 32'd0);
                checkOutput("xferVld", 32'(newPcVld), 32'd0);
            end
        end
        tick();
        busWait = 1'b0;
        @(negedge clk);
        checkOutput("doneVld", 32'(newPcVld), 32'd1);
        checkOutput("doneNewPc", newPc, rdData);
        checkOutput("doneSrI", 32'(newSrI), 32'(lvl));
        checkOutput("doneBusy", 32'(busy), 32'd1);
        checkOutput("doneBusReq", 32'(busReq), 32'd0);
        tick();
        @(negedge clk);
        checkOutput("idleBusy", 32'(busy), 32'd0);
        checkOutput("idleVld", 32'(newPcVld), 32'd0);
    endtask

    initial begin
        errCount = 0; checkCount = 0;
        rst = 1'b1; ceR = 1'b1; intReq = 1'b0; accept = 1'b0; intLvl = 4'h0; intVec = 8'h0;
        srIn = 32'h0; pcIn = 32'h0; r15In = 32'h0; vbrIn = 32'h0; busDi = 32'h0; busWait = 1'b0;

        // Reset state
        tick(); tick();
        @(negedge clk);
        checkOutput("rstBusy", 32'(busy), 32'd0);
        checkOutput("rstBusReq", 32'(busReq), 32'd0);
        checkOutput("rstAck", 32'(intAck), 32'd0);
        checkOutput("rstVld", 32'(newPcVld), 32'd0);
        checkOutput("rstErr", 32'(err), 32'd0);
        checkOutput("rstR15We", 32'(r15We), 32'd0);
        checkOutput("rstAddr", busA, 32'h0);
        tick();
        rst = 1'b0;

        // Zero-wait sequence, then the same with three stall cycles per transfer
        applyStimulus(32'h0FFFF000, 32'h00001234, 32'h000000F0, 32'h0, 8'd64, 4'd5, 0, 32'h00008000,
                      32'h0FFFEFFC, 32'h0FFFEFF8, 32'h00000100);
        applyStimulus(32'h0FFFF000, 32'h00001234, 32'h000000F0, 32'h0, 8'd64, 4'd5, 3, 32'h00009000,
                      32'h0FFFEFFC, 32'h0FFFEFF8, 32'h00000100);

        // Address wrap-around
        applyStimulus(32'h00000004, 32'h00005678, 32'h00000030, 32'hFFFFFF00, 8'h50, 4'hA, 0, 32'hABCD0000,
                      32'h00000000, 32'hFFFFFFFC, 32'h00000040);

        // ACCEPT alone, then INT_REQ without ACCEPT: nothing may start
        accept = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            @(negedge clk);
            checkOutput("acceptOnlyBusy", 32'(busy), 32'd0);
        end
        accept = 1'b0; intReq = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            @(negedge clk);
            checkOutput("noAcceptBusy", 32'(busy), 32'd0);
            checkOutput("noAcceptAck", 32'(intAck), 32'd0);
        end
        applyStimulus(32'h20000000, 32'h00000400, 32'h000000E0, 32'h00000800, 8'h01, 4'd3, 0, 32'h00777700,
                      32'h1FFFFFFC, 32'h1FFFFFF8, 32'h00000804);

        // Bus timeout in PUSH_PC
        intReq = 1'b1; accept = 1'b1;
        r15In = 32'h00002000; pcIn = 32'h00000AAA; srIn = 32'h00000010; vbrIn = 32'h0; intVec = 8'h10; intLvl = 4'd7;
        busWait = 1'b0;
        tick();
        intReq = 1'b0; accept = 1'b0;
        @(negedge clk);
        checkOutput("toAck", 32'(intAck), 32'd1);
        tick();
        @(negedge clk);
        checkOutput("toPushSrAddr", busA, 32'h00001FFC);
        tick();
        busWait = 1'b1;
        for (int w = 0; w < 4; w++) begin
            if (w > 0) tick();
            @(negedge clk);
            checkOutput("toStallReq", 32'(busReq), 32'd1);
            checkOutput("toStallAddr", busA, 32'h00001FF8);
            checkOutput("toStallErr", 32'(err), 32'd0);
            checkOutput("toStallR15We", 32'(r15We), 32'd0);
        end
        tick();
        @(negedge clk);
        checkOutput("toErr", 32'(err), 32'd1);
        checkOutput("toBusy", 32'(busy), 32'd0);
        checkOutput("toBusReq", 32'(busReq), 32'd0);
        checkOutput("toR15We", 32'(r15We), 32'd0);
        tick();
        @(negedge clk);
        checkOutput("toErrCleared", 32'(err), 32'd0);
        checkOutput("toR15WeAfter", 32'(r15We), 32'd0);
        busWait = 1'b0;

        // CE freeze holds the ACK pulse, then reset lands mid vector read
        intReq = 1'b1; accept = 1'b1;
        r15In = 32'h00003000; pcIn = 32'h00000BBB; srIn = 32'h00000020; vbrIn = 32'h0; intVec = 8'h20; intLvl = 4'd2;
        tick();
        intReq = 1'b0; accept = 1'b0; ceR = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("ceHoldAck", 32'(intAck), 32'd1);
            checkOutput("ceHoldBusReq", 32'(busReq), 32'd0);
            tick();
        end
        ceR = 1'b1;
        @(negedge clk);
        checkOutput("ceResumeAck", 32'(intAck), 32'd1);
        tick();
        @(negedge clk);
        checkOutput("ceResumeAddr", busA, 32'h00002FFC);
        checkOutput("ceResumeAckLow", 32'(intAck), 32'd0);
        tick();
        tick();
        busWait = 1'b1;
        @(negedge clk);
        checkOutput("vecRdVect", 32'(vectReq), 32'd1);
        checkOutput("vecRdR15We", 32'(r15We), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midRstBusReq", 32'(busReq), 32'd0);
        checkOutput("midRstVect", 32'(vectReq), 32'd0);
        checkOutput("midRstAddr", busA, 32'h0);
        checkOutput("midRstBusy", 32'(busy), 32'd0);
        checkOutput("midRstR15We", 32'(r15We), 32'd0);
        tick(); tick();
        rst = 1'b0; busWait = 1'b0;
        applyStimulus(32'h40000000, 32'h0000CAFE, 32'h000001F0, 32'h00001000, 8'h0B, 4'd15, 1, 32'h55550000,
                      32'h3FFFFFFC, 32'h3FFFFFF8, 32'h0000102C);

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
